// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and frame constants shared by the UART transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_OVERSAMPLE = 16;
    localparam int   UART_FRAME_BITS = 10;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: valid/ready byte handshake from the packet layer into the serializer.
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);

    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, tx_data, input tx_ready);
    modport slave  (input tx_valid, tx_data, output tx_ready);

endinterface

// File: rtl/uart_tick_divider.sv
// uart_tick_divider: counts oversample ticks and flags the tick that closes one serial bit.
module uart_tick_divider #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic baud_tick,
    output logic bit_end
);

    localparam int W = $clog2(OVERSAMPLE);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (baud_tick)
            cnt <= cnt + 1'b1;
    end

    // OVERSAMPLE is a power of two, so all-ones is the last tick of a bit
    assign bit_end = baud_tick & (&cnt);

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: frames a byte as start, LSB-first data and stop bits on a registered tx line.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    baud_tick,
    uart_tx_serializer_if.slave     tx,
    output logic                    tx_serial,
    output logic                    tx_busy,
    output logic                    char_done,
    output logic [3:0]              bit_index
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shift;
    logic                 bit_end;

    uart_tick_divider #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == IDLE),
        .baud_tick(baud_tick),
        .bit_end  (bit_end)
    );

    assign tx.tx_ready = (state == IDLE);
    assign tx_busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift     <= '0;
            bit_index <= '0;
            char_done <= 1'b0;
            tx_serial <= UART_IDLE_LEVEL;
        end else begin
            char_done <= 1'b0;
            case (state)
                IDLE: if (tx.tx_valid) begin
                    state     <= START;
                    shift     <= tx.tx_data;
                    tx_serial <= ~UART_IDLE_LEVEL;
                end
                START: if (bit_end) begin
                    state     <= DATA;
                    bit_index <= 4'd1;
                    tx_serial <= shift[0];
                end
                DATA: if (bit_end) begin
                    bit_index <= bit_index + 4'd1;
                    if (bit_index == LAST_DATA) begin
                        state     <= STOP;
                        tx_serial <= UART_IDLE_LEVEL;
                    end else begin
                        // next line level is the bit that is about to become shift[0]
                        shift     <= shift >> 1;
                        tx_serial <= shift[1];
                    end
                end
                STOP: if (bit_end) begin
                    state     <= IDLE;
                    bit_index <= '0;
                    char_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
